// File: rtl/mem_bank_pkg.sv
// Shared types, limits and helpers for the mem_bank data memory.
package mem_pkg;

    // Controller states: CLEAR sweeps zeros through the array, RUN serves requests.
    typedef enum logic {
        CLEAR,
        RUN
    } mem_state_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    // One byte lane of a write: keep the stored byte unless its enable is set.
    function automatic logic [7:0] lane_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/mem_bank_if.sv
// Request/response bus of mem_bank. The slave side is the memory,
// the master side is the load-store path driving it.
interface mem_bank_if
    import mem_pkg::*;
#(
    parameter int A = 12,
    parameter int M = 16
);
    logic             req;
    logic             we;
    logic [A-1:0]     address;
    logic [M/8-1:0]   be;
    logic [M-1:0]     data_in;
    logic             clear;
    logic             ready;
    logic             rd_valid;
    logic [M-1:0]     data_out;

    modport master (
        output req, we, address, be, data_in, clear,
        input  ready, rd_valid, data_out
    );

    modport slave (
        input  req, we, address, be, data_in, clear,
        output ready, rd_valid, data_out
    );

endinterface

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline: LAT stages of {valid, data}. The last stage only
// loads on a valid result, so data_out holds the most recent read.
module mem_rd_pipe
    import mem_pkg::*;
#(
    parameter int M   = 16,
    parameter int LAT = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         rd_acc,
    input  logic [M-1:0] rd_word,
    output logic         rd_valid,
    output logic [M-1:0] data_out
);

    logic [LAT-1:0] vld_p;
    logic [M-1:0]   dat_p [LAT];
    logic [LAT-1:0] vld_d;
    logic [M-1:0]   dat_d [LAT];

    // Stage inputs: stage 0 takes the accepted read, later stages shift.
    always_comb begin
        vld_d[0] = rd_acc;
        dat_d[0] = rd_word;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_p[i-1];
            dat_d[i] = dat_p[i-1];
        end
    end

    // Stage registers; reset flushes every stage and zeroes the output.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_p[i] <= '0;
            end
        end else begin
            vld_p <= vld_d;
            for (int i = 0; i < LAT; i++) begin
                if (i < LAT - 1 || vld_d[i]) begin
                    dat_p[i] <= dat_d[i];
                end
            end
        end
    end

    assign rd_valid = vld_p[LAT-1];
    assign data_out = dat_p[LAT-1];

endmodule

// File: rtl/mem_bank.sv
// Single-port data memory with request/ready handshake, byte-lane writes,
// pipelined reads, optional hardwired-zero word 0 and a clear sweep.
module mem_bank
    import mem_pkg::*;
#(
    parameter int A              = 12,
    parameter int M              = 16,
    parameter int LAT            = 1,
    parameter int ZERO_ADDR0     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic      CLK,
    input  logic      RST_N,
    mem_bank_if.slave bus
);

    localparam int D = 2**A;
    localparam int B = M / 8;

    if ((M % 8) != 0 || M < 8) begin : g_bad_width
        $error("mem_bank: M (%0d) must be a non-zero multiple of 8", M);
    end
    if (LAT < MEM_LAT_MIN || LAT > MEM_LAT_MAX) begin : g_bad_lat
        $error("mem_bank: LAT (%0d) outside %0d..%0d", LAT, MEM_LAT_MIN, MEM_LAT_MAX);
    end

    mem_state_t   state, state_nxt;
    logic [A-1:0] cnt, cnt_nxt;
    logic         ready_run;
    logic         wr_acc, rd_acc, addr_zero;
    logic [M-1:0] mem [D];
    logic [M-1:0] rd_raw, rd_word, wr_word;

    // State and sweep counter; the array itself is never reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: sweep to the last word then run; clear restarts the sweep.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_run = 1'b0;
        case (state)
            CLEAR: begin
                if (cnt == A'(D - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                ready_run = !bus.clear;
                if (bus.clear) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ready is also held low while reset is asserted, whatever the reset state.
    assign bus.ready = ready_run && RST_N;
    assign wr_acc    = bus.req && bus.ready && bus.we;
    assign rd_acc    = bus.req && bus.ready && !bus.we;
    assign addr_zero = (ZERO_ADDR0 != 0) && (bus.address == '0);
    assign rd_raw    = mem[bus.address];
    assign rd_word   = addr_zero ? '0 : rd_raw;

    // Byte-lane merge of the write data over the currently stored word.
    always_comb begin
        wr_word = rd_raw;
        for (int i = 0; i < B; i++) begin
            wr_word[8*i +: 8] = lane_merge(rd_raw[8*i +: 8], bus.data_in[8*i +: 8], bus.be[i]);
        end
    end

    // Array write port: sweep zeros take priority (no request is accepted then).
    always_ff @(posedge CLK) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_acc && !addr_zero) begin
            mem[bus.address] <= wr_word;
        end
    end

    mem_rd_pipe #(
        .M   (M),
        .LAT (LAT)
    ) u_rd_pipe (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .rd_acc   (rd_acc),
        .rd_word  (rd_word),
        .rd_valid (bus.rd_valid),
        .data_out (bus.data_out)
    );

endmodule
